// File: rtl/data_req_issue_pkg.sv
// Shared definitions for the data-memory request issuer: opcodes, bus
// transfer sizes, FSM states and the registered request bundle.
package data_req_issue_pkg;

    localparam int unsigned MEM_OP_W = 4;

    localparam logic [MEM_OP_W-1:0] MEM_OP_LB  = 4'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LBU = 4'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LH  = 4'd2;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LHU = 4'd3;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LW  = 4'd4;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LWL = 4'd5;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LWR = 4'd6;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SB  = 4'd8;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SH  = 4'd9;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SW  = 4'd10;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SWL = 4'd11;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SWR = 4'd12;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } req_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_req_t;

    // True for every opcode the data path understands.
    function automatic logic op_is_legal(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW,
            MEM_OP_LWL, MEM_OP_LWR, MEM_OP_SB, MEM_OP_SH, MEM_OP_SW,
            MEM_OP_SWL, MEM_OP_SWR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Halfword ops need an even address, full-word ops a word address;
    // the unaligned-word ops (LWL/LWR/SWL/SWR) are never misaligned.
    function automatic logic op_is_misaligned(input logic [MEM_OP_W-1:0] op,
                                              input logic [1:0]          a);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return a[0];
            MEM_OP_LW, MEM_OP_SW:             return (a != 2'b00);
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_tag_fifo.sv
// Small synchronous FIFO holding one tag per in-flight bus transaction.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module mem_tag_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = r_mem[r_rd_ptr];

    // Tag storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_req_issue.sv
// Data-memory request issuer: turns EXE memory ops into aligned SRAM-like bus
// requests, holds them until addr_ok, tracks outstanding transactions and
// filters out responses that belong to flushed ops.
module data_req_issue
    import data_req_issue_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        flush,
    output logic        ale,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        rsp_valid,
    output logic        rsp_is_load
);

    localparam int unsigned OW = CNT_W + 1;

    req_state_e       r_state;
    req_state_e       w_state_next;
    bus_req_t         r_req;
    bus_req_t         w_req_enc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;
    logic             r_ale;

    logic             w_hs;
    logic             w_dok;
    logic [OW-1:0]    w_out_next_wide;
    logic [CNT_W-1:0] w_out_next;
    logic             w_accept;
    logic             w_legal;
    logic             w_misaligned;
    logic             w_issue;
    logic             w_fifo_head;
    logic             w_fifo_empty;
    logic             w_fifo_full;

    // Bus encoding of one op. SWL/SWR express their lane pattern as shifts of
    // an all-ones strobe and of rt, keyed on the byte offset.
    function automatic bus_req_t encode_req(input logic [3:0]  op,
                                            input logic [31:0] addr,
                                            input logic [31:0] rt);
        bus_req_t   r;
        logic [1:0] a;
        r      = '0;
        a      = addr[1:0];
        r.addr = addr;
        case (op)
            MEM_OP_LB, MEM_OP_LBU: r.size = SIZE_BYTE;
            MEM_OP_LH, MEM_OP_LHU: r.size = SIZE_HALF;
            MEM_OP_LW:             r.size = SIZE_WORD;
            MEM_OP_LWL, MEM_OP_LWR: begin
                r.size = SIZE_WORD;
                r.addr = {addr[31:2], 2'b00};
            end
            MEM_OP_SB: begin
                r.wr    = 1'b1;
                r.size  = SIZE_BYTE;
                r.wstrb = 4'b0001 << a;
                r.wdata = {4{rt[7:0]}};
            end
            MEM_OP_SH: begin
                r.wr    = 1'b1;
                r.size  = SIZE_HALF;
                r.wstrb = a[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{rt[15:0]}};
            end
            MEM_OP_SW: begin
                r.wr    = 1'b1;
                r.size  = SIZE_WORD;
                r.wstrb = 4'b1111;
                r.wdata = rt;
            end
            MEM_OP_SWL: begin
                r.wr    = 1'b1;
                r.size  = SIZE_WORD;
                r.addr  = {addr[31:2], 2'b00};
                r.wstrb = 4'b1111 >> (2'd3 - a);
                r.wdata = rt >> {(2'd3 - a), 3'b000};
            end
            MEM_OP_SWR: begin
                r.wr    = 1'b1;
                r.size  = SIZE_WORD;
                r.addr  = {addr[31:2], 2'b00};
                r.wstrb = 4'b1111 << a;
                r.wdata = rt << {a, 3'b000};
            end
            default: ;
        endcase
        return r;
    endfunction

    assign w_hs  = (r_state == ST_REQ) && data_sram_addr_ok;
    // A stray data_ok with nothing in flight is dropped here.
    assign w_dok = data_sram_data_ok && (r_outstanding != '0);

    assign w_out_next_wide = {1'b0, r_outstanding} + OW'(w_hs) - OW'(w_dok);
    assign w_out_next      = w_out_next_wide[CNT_W-1:0];

    assign in_ready = !flush
                   && ((r_state == ST_IDLE) || data_sram_addr_ok)
                   && (w_out_next_wide < OW'(MAX_OUTSTANDING));

    assign w_accept     = in_valid && in_ready;
    assign w_legal      = op_is_legal(in_op);
    assign w_misaligned = op_is_misaligned(in_op, in_addr[1:0]);
    assign w_issue      = w_accept && w_legal && !w_misaligned;
    assign w_req_enc    = encode_req(in_op, in_addr, in_wdata);

    assign data_sram_req   = (r_state == ST_REQ);
    assign data_sram_wr    = r_req.wr;
    assign data_sram_size  = r_req.size;
    assign data_sram_addr  = r_req.addr;
    assign data_sram_wstrb = r_req.wstrb;
    assign data_sram_wdata = r_req.wdata;
    assign ale             = r_ale;

    assign rsp_valid   = w_dok && (r_discard == '0);
    assign rsp_is_load = w_fifo_head;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a new issue always lands in REQ; REQ drops to IDLE once the
    // bus takes the request and nothing new follows it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_state_next = ST_REQ;
            ST_REQ:  if (data_sram_addr_ok && !w_issue) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured only when an aligned op is accepted and
    // then held untouched until the handshake completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= '0;
        end else if (w_issue) begin
            r_req <= w_req_enc;
        end
    end

    // Misalignment exception pulse, one cycle after the faulting accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ale <= 1'b0;
        end else begin
            r_ale <= w_accept && w_legal && w_misaligned;
        end
    end

    // Outstanding count and the number of upcoming responses to swallow.
    // On flush the pending, not-yet-taken request is counted too since it
    // will still complete its handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (flush) begin
                r_discard <= w_out_next
                           + CNT_W'((r_state == ST_REQ) && !data_sram_addr_ok);
            end else if (w_dok && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
        end
    end

    mem_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_hs),
        .din   (!r_req.wr),
        .pop   (w_dok),
        .dout  (w_fifo_head),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

`ifndef SYNTHESIS
    // A response with nothing outstanding means the bus broke protocol.
    assert property (@(posedge clk) disable iff (reset)
        !(data_sram_data_ok && (r_outstanding == '0)))
        else $error("data_req_issue: data_ok with no outstanding transaction");

    // The tag FIFO must track the outstanding count exactly.
    assert property (@(posedge clk) disable iff (reset)
        !((w_hs && w_fifo_full && !w_dok) || (w_dok && w_fifo_empty)))
        else $error("data_req_issue: tag FIFO out of step with outstanding count");
`endif

endmodule

// File: tb/tb_data_req_issue.sv
// Self-checking bench for data_req_issue: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_data_req_issue;

    localparam int unsigned MAXO = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        flush;
    logic        ale;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic        rsp_valid;
    logic        rsp_is_load;

    int errors = 0;
    int checks = 0;

    data_req_issue #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_op             (in_op),
        .in_addr           (in_addr),
        .in_wdata          (in_wdata),
        .flush             (flush),
        .ale               (ale),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .rsp_valid         (rsp_valid),
        .rsp_is_load       (rsp_is_load)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        in_valid          = 1'b0;
        in_op             = 4'd0;
        in_addr           = 32'd0;
        in_wdata          = 32'd0;
        flush             = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference encoding built lane by lane from the ISA's memory semantics.
    function automatic void ref_encode(input logic [3:0] op, input logic [31:0] addr,
                                       input logic [31:0] rt, output bit legal, output bit mis,
                                       output logic wr, output logic [1:0] size,
                                       output logic [31:0] raddr, output logic [3:0] strb,
                                       output logic [31:0] wdata);
        int a;
        logic [7:0] lane [4];
        a = int'(addr[1:0]);
        legal = 1; mis = 0; wr = 1'b0; size = 2'd2; raddr = addr; strb = 4'b0000;
        for (int i = 0; i < 4; i++) lane[i] = 8'h00;
        case (op)
            4'd0, 4'd1: size = 2'd0;
            4'd2, 4'd3: begin size = 2'd1; mis = addr[0]; end
            4'd4:       mis = (a != 0);
            4'd5, 4'd6: raddr = addr & ~32'h3;
            4'd8: begin
                wr = 1'b1; size = 2'd0; strb[a] = 1'b1;
                for (int i = 0; i < 4; i++) lane[i] = rt[7:0];
            end
            4'd9: begin
                wr = 1'b1; size = 2'd1; mis = addr[0];
                strb[a & 2] = 1'b1; strb[(a & 2) + 1] = 1'b1;
                for (int i = 0; i < 4; i++) lane[i] = rt[8*(i%2) +: 8];
            end
            4'd10: begin
                wr = 1'b1; mis = (a != 0); strb = 4'b1111;
                for (int i = 0; i < 4; i++) lane[i] = rt[8*i +: 8];
            end
            4'd11: begin
                wr = 1'b1; raddr = addr & ~32'h3;
                for (int i = 0; i <= a; i++) begin strb[i] = 1'b1; lane[i] = rt[8*(3-a+i) +: 8]; end
            end
            4'd12: begin
                wr = 1'b1; raddr = addr & ~32'h3;
                for (int i = a; i < 4; i++) begin strb[i] = 1'b1; lane[i] = rt[8*(i-a) +: 8]; end
            end
            default: legal = 0;
        endcase
        wdata = {lane[3], lane[2], lane[1], lane[0]};
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({data_sram_req, ale, rsp_valid, in_ready} !== 4'b0001) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0001", {data_sram_req, ale, rsp_valid, in_ready});
        end
        checks++;
        if ({data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata} !== 71'd0) begin
            errors++; $display("FAIL reset_req_regs: got %h want 0",
                {data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata});
        end
        checks++;
        if ({dut.r_outstanding, dut.r_discard} !== 4'd0) begin
            errors++; $display("FAIL reset_counters: got %b want 0000", {dut.r_outstanding, dut.r_discard});
        end
    endtask

    task automatic test_sb();
        do_reset();
        @(negedge clk); set_idle(); drive_op(4'd8, 32'h1003, 32'h000000A5); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL sb_ready: got %b want 1", in_ready); end
        @(negedge clk); set_idle(); data_sram_addr_ok = 1'b1; #1;
        checks++;
        if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata}
            !== {1'b1, 1'b1, 2'd0, 32'h1003, 4'b1000, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL sb_fields: got %b %b %0d %h %b %h want 1 1 0 00001003 1000 a5a5a5a5",
                data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata);
        end
        @(negedge clk); set_idle(); data_sram_data_ok = 1'b1; #1;
        checks++;
        if (dut.r_outstanding !== 2'd1) begin errors++; $display("FAIL sb_outstanding: got %0d want 1", dut.r_outstanding); end
        checks++;
        if ({data_sram_req, rsp_valid, rsp_is_load} !== 3'b010) begin
            errors++; $display("FAIL sb_rsp: got %b want 010", {data_sram_req, rsp_valid, rsp_is_load});
        end
        @(negedge clk); set_idle();
    endtask

    task automatic test_swl_swr();
        do_reset();
        @(negedge clk); set_idle(); drive_op(4'd11, 32'h2001, 32'h11223344);
        @(negedge clk); set_idle(); drive_op(4'd12, 32'h2002, 32'h11223344); data_sram_addr_ok = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL swr_b2b_ready: got %b want 1", in_ready); end
        checks++;
        if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata}
            !== {1'b1, 1'b1, 2'd2, 32'h2000, 4'b0011, 32'h00001122}) begin
            errors++; $display("FAIL swl_fields: got %b %b %0d %h %b %h want 1 1 2 00002000 0011 00001122",
                data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata);
        end
        @(negedge clk); set_idle(); data_sram_addr_ok = 1'b1; #1;
        checks++;
        if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata}
            !== {1'b1, 1'b1, 2'd2, 32'h2000, 4'b1100, 32'h33440000}) begin
            errors++; $display("FAIL swr_fields: got %b %b %0d %h %b %h want 1 1 2 00002000 1100 33440000",
                data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_idle(); data_sram_data_ok = 1'b1; #1;
            checks++;
            if ({data_sram_req, rsp_valid, rsp_is_load} !== 3'b010) begin
                errors++; $display("FAIL swlr_rsp%0d: got %b want 010", i, {data_sram_req, rsp_valid, rsp_is_load});
            end
        end
        @(negedge clk); set_idle();
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h3000, $urandom); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_first_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_idle(); drive_op(4'd4, 32'h3004, $urandom); data_sram_addr_ok = (i == 3); #1;
            checks++;
            if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata}
                !== {1'b1, 1'b0, 2'd2, 32'h3000, 4'b0000, 32'h0}) begin
                errors++; $display("FAIL stall_hold%0d: got %b %b %0d %h %b %h want 1 0 2 00003000 0000 00000000", i,
                    data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata);
            end
            checks++;
            if (in_ready !== (i == 3)) begin errors++; $display("FAIL stall_ready%0d: got %b want %b", i, in_ready, i == 3); end
        end
        @(negedge clk); set_idle(); data_sram_addr_ok = 1'b1; #1;
        checks++;
        if ({data_sram_req, data_sram_addr} !== {1'b1, 32'h3004}) begin
            errors++; $display("FAIL stall_b2b: got %b %h want 1 00003004", data_sram_req, data_sram_addr);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_idle(); data_sram_data_ok = 1'b1; #1;
            checks++;
            if ({rsp_valid, rsp_is_load} !== 2'b11) begin
                errors++; $display("FAIL stall_rsp%0d: got %b want 11", i, {rsp_valid, rsp_is_load});
            end
        end
        @(negedge clk); set_idle();
    endtask

    task automatic test_outstanding();
        do_reset();
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h100, 32'h0);
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h104, 32'h0); data_sram_addr_ok = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL outs_second_ready: got %b want 1", in_ready); end
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h108, 32'h0); data_sram_addr_ok = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL outs_third_stall: got %b want 0", in_ready); end
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h108, 32'h0); #1;
        checks++;
        if ({in_ready, data_sram_req, dut.r_outstanding} !== 4'b0010) begin
            errors++; $display("FAIL outs_full: got %b want 0010", {in_ready, data_sram_req, dut.r_outstanding});
        end
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h108, 32'h0); data_sram_data_ok = 1'b1; #1;
        checks++;
        if ({in_ready, rsp_valid, rsp_is_load} !== 3'b111) begin
            errors++; $display("FAIL outs_release: got %b want 111", {in_ready, rsp_valid, rsp_is_load});
        end
        @(negedge clk); set_idle(); data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; #1;
        checks++;
        if ({data_sram_req, data_sram_addr, rsp_valid, rsp_is_load} !== {1'b1, 32'h108, 2'b11}) begin
            errors++; $display("FAIL outs_third_issue: got %b %h %b want 1 00000108 11",
                data_sram_req, data_sram_addr, {rsp_valid, rsp_is_load});
        end
        @(negedge clk); set_idle(); data_sram_data_ok = 1'b1; #1;
        checks++;
        if ({dut.r_outstanding, rsp_valid, rsp_is_load} !== 4'b0111) begin
            errors++; $display("FAIL outs_last_rsp: got %b want 0111", {dut.r_outstanding, rsp_valid, rsp_is_load});
        end
        @(negedge clk); set_idle(); #1;
        checks++;
        if (dut.r_outstanding !== 2'd0) begin errors++; $display("FAIL outs_drained: got %0d want 0", dut.r_outstanding); end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk); set_idle(); drive_op(4'd0, 32'h200, 32'h0);
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h204, 32'h0); data_sram_addr_ok = 1'b1;
        @(negedge clk); set_idle(); data_sram_addr_ok = 1'b1;
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h300, 32'h0); flush = 1'b1; #1;
        checks++;
        if ({in_ready, dut.r_outstanding} !== 3'b010) begin
            errors++; $display("FAIL flush_blocks_accept: got %b want 010", {in_ready, dut.r_outstanding});
        end
        @(negedge clk); set_idle(); #1;
        checks++;
        if ({data_sram_req, dut.r_discard} !== 3'b010) begin
            errors++; $display("FAIL flush_discard: got %b want 010", {data_sram_req, dut.r_discard});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_idle(); data_sram_data_ok = 1'b1; #1;
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_drop%0d: got %b want 0", i, rsp_valid); end
        end
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h400, 32'h0); #1;
        checks++;
        if ({in_ready, dut.r_discard} !== 3'b100) begin
            errors++; $display("FAIL flush_after_ready: got %b want 100", {in_ready, dut.r_discard});
        end
        @(negedge clk); set_idle(); data_sram_addr_ok = 1'b1;
        @(negedge clk); set_idle(); data_sram_data_ok = 1'b1; #1;
        checks++;
        if ({rsp_valid, rsp_is_load} !== 2'b11) begin
            errors++; $display("FAIL flush_live_rsp: got %b want 11", {rsp_valid, rsp_is_load});
        end
        // Flush while a request is still waiting for addr_ok.
        @(negedge clk); set_idle(); drive_op(4'd10, 32'h500, 32'h0);
        @(negedge clk); set_idle(); flush = 1'b1;
        @(negedge clk); set_idle(); data_sram_addr_ok = 1'b1; #1;
        checks++;
        if ({data_sram_req, data_sram_addr, dut.r_discard} !== {1'b1, 32'h500, 2'd1}) begin
            errors++; $display("FAIL flush_pending: got %b %h %0d want 1 00000500 1",
                data_sram_req, data_sram_addr, dut.r_discard);
        end
        @(negedge clk); set_idle(); data_sram_data_ok = 1'b1; #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_pending_drop: got %b want 0", rsp_valid); end
        @(negedge clk); set_idle(); #1;
        checks++;
        if ({dut.r_outstanding, dut.r_discard} !== 4'd0) begin
            errors++; $display("FAIL flush_clean: got %b want 0000", {dut.r_outstanding, dut.r_discard});
        end
    endtask

    task automatic test_misaligned();
        logic [3:0] ops [3];
        logic [31:0] adr [3];
        logic [1:0] want [3];
        ops[0] = 4'd2; adr[0] = 32'h4001; want[0] = 2'b10;
        ops[1] = 4'd7; adr[1] = 32'h4000; want[1] = 2'b00;
        ops[2] = 4'd10; adr[2] = 32'h4002; want[2] = 2'b10;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_idle(); drive_op(ops[i], adr[i], 32'hFFFF_FFFF); #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL mis_ready%0d: got %b want 1", i, in_ready); end
            @(negedge clk); set_idle(); #1;
            checks++;
            if ({ale, data_sram_req} !== want[i]) begin
                errors++; $display("FAIL mis_pulse%0d: got %b want %b", i, {ale, data_sram_req}, want[i]);
            end
            @(negedge clk); set_idle(); #1;
            checks++;
            if ({ale, data_sram_req} !== 2'b00) begin
                errors++; $display("FAIL mis_clear%0d: got %b want 00", i, {ale, data_sram_req});
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h500, 32'h0);
        @(negedge clk); set_idle(); drive_op(4'd4, 32'h504, 32'h0); data_sram_addr_ok = 1'b1;
        @(negedge clk); set_idle(); #1;
        checks++;
        if ({data_sram_req, dut.r_outstanding} !== 3'b101) begin
            errors++; $display("FAIL areset_pre: got %b want 101", {data_sram_req, dut.r_outstanding});
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({data_sram_req, dut.r_outstanding, dut.r_discard} !== 5'b0) begin
            errors++; $display("FAIL areset_immediate: got %b want 00000",
                {data_sram_req, dut.r_outstanding, dut.r_discard});
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_random();
        bit          m_pend, m_dead, m_ale;
        logic        m_wr;
        logic [1:0]  m_size;
        logic [31:0] m_addr, m_wdata;
        logic [3:0]  m_strb;
        bit          q_live [$];
        bit          q_load [$];
        bit          hs, pop, e_ready, acc, lg, ms;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        do_reset();
        m_pend = 0; m_dead = 0; m_ale = 0;
        m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_strb = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            set_idle();
            in_valid = ($urandom_range(0, 2) != 0);
            in_op    = 4'($urandom_range(0, 15));
            in_addr  = $urandom;
            if ($urandom_range(0, 1) == 1) in_addr[1:0] = 2'b00;
            in_wdata = $urandom;
            flush    = ($urandom_range(0, 15) == 0);
            data_sram_addr_ok = 1'($urandom_range(0, 1));
            data_sram_data_ok = (q_live.size() > 0) && ($urandom_range(0, 2) == 0);
            #1;
            hs  = m_pend && data_sram_addr_ok;
            pop = data_sram_data_ok && (q_live.size() > 0);
            e_ready = !flush && (!m_pend || data_sram_addr_ok)
                   && ((q_live.size() + int'(hs) - int'(pop)) < int'(MAXO));
            checks++;
            if (in_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, e_ready); end
            checks++;
            if ({data_sram_req, ale} !== {m_pend, m_ale}) begin
                errors++; $display("FAIL rnd_req_ale c%0d: got %b want %b", cyc, {data_sram_req, ale}, {m_pend, m_ale});
            end
            if (m_pend) begin
                checks++;
                if ({data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata}
                    !== {m_wr, m_size, m_addr, m_strb, m_wdata}) begin
                    errors++; $display("FAIL rnd_fields c%0d: got %b %0d %h %b %h want %b %0d %h %b %h", cyc,
                        data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
                        m_wr, m_size, m_addr, m_strb, m_wdata);
                end
            end
            checks++;
            if (rsp_valid !== (pop && q_live[0])) begin
                errors++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, rsp_valid, pop && q_live[0]);
            end
            if (pop && q_live[0]) begin
                checks++;
                if (rsp_is_load !== q_load[0]) begin
                    errors++; $display("FAIL rnd_rsp_is_load c%0d: got %b want %b", cyc, rsp_is_load, q_load[0]);
                end
            end
            // Advance the transaction model across the coming clock edge.
            if (pop) begin void'(q_live.pop_front()); void'(q_load.pop_front()); end
            if (hs) begin q_live.push_back(!m_dead); q_load.push_back(!m_wr); end
            if (flush) foreach (q_live[i]) q_live[i] = 0;
            if (flush && m_pend && !data_sram_addr_ok) m_dead = 1;
            acc = in_valid && e_ready;
            ref_encode(in_op, in_addr, in_wdata, lg, ms, e_wr, e_size, e_addr, e_strb, e_wdata);
            m_ale = acc && lg && ms;
            if (acc && lg && !ms) begin
                m_pend = 1; m_dead = 0;
                m_wr = e_wr; m_size = e_size; m_addr = e_addr; m_strb = e_strb; m_wdata = e_wdata;
            end else begin
                m_pend = m_pend && !data_sram_addr_ok;
            end
        end
        @(negedge clk); set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_sb();
        test_swl_swr();
        test_stall();
        test_outstanding();
        test_flush();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_req_issue.md
Name: data_req_issue

Overview:
- Initiator side of the data-memory SRAM-like interface, sitting between the EXE stage and the data bus.
- It converts each EXE memory op into an aligned bus request: size, address, byte strobes and replicated or shifted store data for sb/sh/sw/swl/swr.
- It holds each request until addr_ok, tracks outstanding transactions, and returns data_ok responses tagged load/store.
- Responses for flushed transactions are discarded, so the MEM-stage load extractor only sees live responses.

Parameters:
MAX_OUTSTANDING, 2, max transactions accepted by the bus (addr_ok) but not yet answered (data_ok); legal range 1-4
CNT_W, $clog2(MAX_OUTSTANDING+1), width of outstanding/discard counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  EXE presents a memory op
in_ready  out  1  op accepted this cycle when in_valid&in_ready
in_op  in  4  0 LB,1 LBU,2 LH,3 LHU,4 LW,5 LWL,6 LWR,8 SB,9 SH,10 SW,11 SWL,12 SWR; others illegal
in_addr  in  32  effective address
in_wdata  in  32  rt value for stores
flush  in  1  exception/eret flush; kills pending and in-flight ops
ale  out  1  one-cycle pulse: accepted op misaligned, no bus request issued
data_sram_req  out  1  request valid
data_sram_wr  out  1  1 store, 0 load
data_sram_size  out  2  0 byte,1 half,2 word
data_sram_addr  out  32  request address
data_sram_wstrb  out  4  byte strobes (0 for loads)
data_sram_wdata  out  32  aligned store data
data_sram_addr_ok  in  1  request taken
data_sram_data_ok  in  1  response for oldest outstanding transaction
rsp_valid  out  1  live response to MEM stage
rsp_is_load  out  1  response belongs to a load

Behaviour:
- Reset (async): state IDLE, outstanding=0, discard=0, tag FIFO empty; data_sram_req=0, ale=0, all request regs 0.
- FSM: IDLE -> REQ on an accepted aligned op. REQ -> IDLE on addr_ok with no new accept. REQ -> REQ on addr_ok with a back-to-back accept. Request registers are loaded only on accept.
- In REQ, req/wr/size/addr/wstrb/wdata stay stable until addr_ok. flush never retracts an asserted req.
- in_ready = !flush && (state==IDLE || addr_ok) && (outstanding + (req&addr_ok) - data_ok) < MAX_OUTSTANDING.
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is accepted, pulses ale the next cycle, issues no request, and the FSM stays IDLE.
- Store encoding (a=addr[1:0], rt=in_wdata):
  - SB: size 0, addr as given, wstrb=1<<a, wdata={4{rt[7:0]}}.
  - SH: size 1, wstrb=a[1]?1100:0011, wdata={2{rt[15:0]}}.
  - SW: size 2, wstrb 1111, wdata=rt.
  - SWL: addr word-aligned, size 2. a0: 0001,{24'0,rt[31:24]}; a1: 0011,{16'0,rt[31:16]}; a2: 0111,{8'0,rt[31:8]}; a3: 1111,rt.
  - SWR: addr word-aligned, size 2. a0: 1111,rt; a1: 1110,{rt[23:0],8'0}; a2: 1100,{rt[15:0],16'0}; a3: 1000,{rt[7:0],24'0}.
- Load encoding:
  - LB/LBU: size 0, addr as given.
  - LH/LHU: size 1.
  - LW: size 2.
  - LWL/LWR: size 2, addr word-aligned.
  - All loads: wstrb 0000, wdata 0.
- Outstanding counter: +1 on req&addr_ok, -1 on data_ok, unchanged when both occur in the same cycle. A data_ok arriving with outstanding=0 is ignored and flagged by a simulation-only assertion.
- Tag FIFO: depth MAX_OUTSTANDING. Pushes !wr on addr_ok, pops on data_ok, and rsp_is_load = FIFO head.
- flush at cycle t sets discard = outstanding_next + (state==REQ && !addr_ok). The pending REQ completes its handshake and is then counted as a discard.
- data_ok with discard>0: discard decrements, FIFO pops, rsp_valid=0. Otherwise rsp_valid=data_ok (combinational, zero latency).
- flush and in_valid in the same cycle: flush wins, op not accepted.
- Illegal in_op: accepted, ignored (no request, no ale).

Decomposition:
- Shared header: MEM_OP_* opcode constants, SIZE_BYTE/HALF/WORD, opcode width.
- One sub-module, mem_tag_fifo: parameterised depth/width sync FIFO holding the is_load tag with the same async reset. Encoding logic stays inline as combinational functions.

Test Plan:
- SB addr 0x1003, rt 0x000000A5, addr_ok same cycle -> req=1 wr=1 size=0 wstrb=1000 wdata=0xA5A5A5A5; outstanding 1; data_ok next cycle -> rsp_valid=1 rsp_is_load=0.
- SWL addr 0x2001 rt 0x11223344 -> addr 0x2000 size 2 wstrb 0011 wdata 0x00001122. SWR addr 0x2002 -> wstrb 1100 wdata 0x33440000.
- addr_ok held low 3 cycles on LW 0x3000 -> req and all fields stable for 4 cycles; in_ready=0 until the addr_ok cycle; next LW issued back-to-back.
- MAX_OUTSTANDING=2, three LWs, data_ok withheld -> third op stalls with in_ready=0. One data_ok -> third accepted the same cycle; rsp_is_load=1.
- Two loads outstanding, flush -> discard=2; two data_ok -> rsp_valid stays 0. A third op after flush gets rsp_valid=1 on its data_ok.
- LH addr 0x4001 -> ale pulses once, no req. Assert reset mid-REQ -> req=0 and counters 0 immediately, without waiting for a clock edge.
